axi_master_wr_engine: RTL

AXI_MASTER_WR_ENGINE -- requirements
Module: axi_master_wr_engine
Interface
REQ-001 ADDR_W, 32, address width.
REQ-002 DATA_W, 64, data width (32/64/128/256); AWSIZE fixed at log2(DATA_W/8).
REQ-003 ID_W, 4, transaction ID width.
REQ-004 MAX_OUT, 4, max outstanding writes (1..15).
REQ-005 ACLK  in  1  clock; all logic on rising edge.
REQ-006 ARESETn  in  1  asynchronous active-low reset.
REQ-007 cmd_valid  in  1  decoder command valid.
REQ-008 cmd_ready  out  1  command accepted when valid&ready.
REQ-009 cmd_id  in  ID_W  transaction ID.
REQ-010 cmd_addr  in  ADDR_W  start address.
REQ-011 cmd_len  in  8  beats minus one.
REQ-012 cmd_burst  in  2  FIXED=0, INCR=1, WRAP=2.
REQ-013 wd_valid  in  1  write-data beat valid.
REQ-014 wd_ready  out  1  write-data beat accepted.
REQ-015 wd_data  in  DATA_W  beat data.
REQ-016 wd_strb  in  DATA_W/8  beat byte strobes.
REQ-017 rsp_valid  out  1  one-cycle response pulse.
REQ-018 rsp_id  out  ID_W  BID of response.
REQ-019 rsp_resp  out  2  BRESP of response.
REQ-020 cmd_err  out  1  one-cycle pulse: illegal command dropped.
REQ-021 AWID  out  ID_W  write address ID.
REQ-022 AWADDR  out  ADDR_W  write address.
REQ-023 AWLEN  out  8  burst length minus one.
REQ-024 AWSIZE  out  3  beat size.
REQ-025 AWBURST  out  2  burst type.
REQ-026 AWVALID  out  1  address valid.
REQ-027 AWREADY  in  1  slave address ready.
REQ-028 WDATA  out  DATA_W  write data (= wd_data).
REQ-029 WSTRB  out  DATA_W/8  write strobes (= wd_strb).
REQ-030 WLAST  out  1  last beat of burst.
REQ-031 WVALID  out  1  write data valid (= wd_valid in W state).
REQ-032 WREADY  in  1  slave data ready; wd_ready = WREADY in W state, else 0.
REQ-033 BID  in  ID_W  response ID.
REQ-034 BRESP  in  2  response code.
REQ-035 BVALID  in  1  response valid.
REQ-036 BREADY  out  1  held 1 whenever out of reset.
Function
REQ-037 FSM IDLE->CHK->AW->W->IDLE; cmd_ready=1 only in IDLE with outstanding<MAX_OUT; accept latches cmd fields and moves to CHK.
REQ-038 CHK (one cycle) flags illegal: burst=3; FIXED len>15; WRAP len not in {1,3,7,15} or addr not aligned to (len+1)*DATA_W/8; INCR addr[11:0]+(len+1)*DATA_W/8>4096; illegal -> cmd_err pulse, back to IDLE, nothing issued; legal -> AW.
REQ-039 AW: AWVALID=1 with latched fields stable until AWREADY sampled high, then W; first AWVALID is the cycle after CHK.
REQ-040 W: beat counter loads cmd_len; decrements per WVALID&WREADY; WLAST=1 when counter=0; last handshake -> IDLE; zero-cycle gap beats allowed.
REQ-041 Outstanding counter +1 on AW handshake, -1 on BVALID (BREADY=1); simultaneous events leave it unchanged; never exceeds MAX_OUT nor underflows (spurious BVALID at 0 ignored, no rsp).
REQ-042 rsp_valid/rsp_id/rsp_resp registered: one cycle after each B handshake.
Reset
REQ-043 ARESETn low: state IDLE, counters 0, AWVALID/WVALID/WLAST/rsp_valid/cmd_err/cmd_ready/BREADY 0, address fields 0; mid-burst reset abandons burst, no resumption.
Structure
REQ-044 Shared package axi_pkg holds burst encodings, BRESP codes, 4 KB constant; one sub-module axi_burst_check (combinational CHK legality).
Verification
REQ-045 INCR addr 0x1000 len 3, AWREADY=1 -> AW one cycle after CHK, 4 beats, WLAST on beat 4, BRESP=0 -> rsp_valid 1 cycle later with cmd_id.
REQ-046 INCR addr 0x0FF8 len 1 -> cmd_err pulse, no AWVALID, outstanding stays 0.
REQ-047 MAX_OUT=4, five commands, BVALID held 0 -> cmd_ready 0 after fourth AW; one B returns -> fifth accepted.
REQ-048 WRAP addr 0x20 len 3 legal; WRAP addr 0x28 len 3 -> cmd_err; FIXED len 16 -> cmd_err.
REQ-049 AWREADY held low 5 cycles -> AWVALID/AWADDR stable throughout; BVALID coincident with AW handshake -> outstanding unchanged.
REQ-050 ARESETn low during beat 2 of len 7 -> all outputs reset values; subsequent command completes normally.

---
 rtl/axi_pkg.sv | 29 ++
 rtl/axi_burst_check.sv | 37 +++
 rtl/axi_master_wr_engine.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and constants for the write-engine slice.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    localparam int unsigned BOUNDARY_4K = 4096;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CHK  = 2'd1,
        ST_AW   = 2'd2,
        ST_W    = 2'd3
    } wr_state_e;

    function automatic logic [2:0] axsize(input int unsigned data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/axi_burst_check.sv
// Combinational legality check of a latched write command (burst type,
// length, wrap alignment, 4 KB crossing).
module axi_burst_check
    import axi_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [13:0] addr_lo,
    input  logic [7:0]  len,
    input  logic [1:0]  burst,
    output logic        illegal
);

    localparam int BEAT_B = DATA_W / 8;

    logic [13:0] bytes;
    logic [13:0] end_off;
    logic        wrap_len_ok;
    logic        wrap_aligned;

    // Largest burst is 256 beats * 32 bytes = 8 KB, so 14 bits cover it.
    assign bytes        = ({6'd0, len} + 14'd1) * 14'(BEAT_B);
    assign end_off      = {2'b00, addr_lo[11:0]} + bytes;
    assign wrap_len_ok  = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    assign wrap_aligned = (addr_lo & (bytes - 14'd1)) == 14'd0;

    always_comb begin
        illegal = 1'b0;
        case (burst)
            BURST_FIXED: illegal = (len > 8'd15);
            BURST_INCR:  illegal = (end_off > 14'(BOUNDARY_4K));
            BURST_WRAP:  illegal = !(wrap_len_ok && wrap_aligned);
            default:     illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/axi_master_wr_engine.sv
// AXI4 write master: accepts one command at a time, checks legality,
// issues AW then streams W beats, tracks outstanding B responses.
module axi_master_wr_engine
    import axi_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int ID_W    = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [7:0]          cmd_len,
    input  logic [1:0]          cmd_burst,
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic [DATA_W/8-1:0] wd_strb,
    output logic                rsp_valid,
    output logic [ID_W-1:0]     rsp_id,
    output logic [1:0]          rsp_resp,
    output logic                cmd_err,
    output logic [ID_W-1:0]     AWID,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [7:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [ID_W-1:0]     BID,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    wr_state_e         state_q, state_d;
    logic              run_q;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [1:0]        burst_q;
    logic [7:0]        beat_q;
    logic [CNT_W-1:0]  out_q;
    logic              illegal;
    logic              cmd_hs, aw_hs, w_hs, b_hs;

    axi_burst_check #(.DATA_W(DATA_W)) u_chk (
        .addr_lo (addr_q[13:0]),
        .len     (len_q),
        .burst   (burst_q),
        .illegal (illegal)
    );

    assign cmd_hs = cmd_valid & cmd_ready;
    assign aw_hs  = AWVALID & AWREADY;
    assign w_hs   = WVALID & WREADY;
    // A B beat with nothing outstanding is spurious: no count change, no rsp.
    assign b_hs   = BVALID & BREADY & (out_q != '0);

    assign BREADY  = run_q;
    assign AWID    = id_q;
    assign AWADDR  = addr_q;
    assign AWLEN   = len_q;
    assign AWBURST = burst_q;
    assign AWSIZE  = axsize(DATA_W);
    assign WDATA   = wd_data;
    assign WSTRB   = wd_strb;

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        cmd_err   = 1'b0;
        AWVALID   = 1'b0;
        WVALID    = 1'b0;
        wd_ready  = 1'b0;
        WLAST     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = run_q && (out_q < CNT_W'(MAX_OUT));
                if (cmd_valid && run_q && (out_q < CNT_W'(MAX_OUT))) state_d = ST_CHK;
            end
            ST_CHK: begin
                if (illegal) begin
                    cmd_err = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_AW;
                end
            end
            ST_AW: begin
                AWVALID = 1'b1;
                if (AWREADY) state_d = ST_W;
            end
            ST_W: begin
                WVALID   = wd_valid;
                wd_ready = WREADY;
                WLAST    = (beat_q == 8'd0);
                if (wd_valid && WREADY && beat_q == 8'd0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
        end else if (cmd_hs) begin
            id_q    <= cmd_id;
            addr_q  <= cmd_addr;
            len_q   <= cmd_len;
            burst_q <= cmd_burst;
        end
    end

    // Beats remaining after the current one; zero marks WLAST.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)   beat_q <= '0;
        else if (aw_hs) beat_q <= len_q;
        else if (w_hs)  beat_q <= beat_q - 8'd1;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            out_q <= '0;
        end else begin
            case ({aw_hs, b_hs})
                2'b10:   out_q <= out_q + CNT_W'(1);
                2'b01:   out_q <= out_q - CNT_W'(1);
                default: out_q <= out_q;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_resp  <= '0;
        end else begin
            rsp_valid <= b_hs;
            if (b_hs) begin
                rsp_id   <= BID;
                rsp_resp <= BRESP;
            end
        end
    end

endmodule
